// File: rtl/noise_channel_if.sv
// Register-field and status bundle between sound_registers and the noise channel.
// The master drives NR41-NR44 fields and frame-sequencer pulses; the slave returns level/on_flag.
interface noise_channel_if;
    logic       length_tick;
    logic       env_tick;
    logic [5:0] length_data;
    logic [3:0] initial_volume;
    logic       envelope_increasing;
    logic [2:0] num_envelope_sweeps;
    logic [3:0] shift_clock_freq_data;
    logic       counter_width;
    logic [2:0] freq_dividing_ratio;
    logic       initialize;
    logic       dont_loop;
    logic [3:0] level;
    logic       on_flag;

    modport master (
        output length_tick, env_tick, length_data, initial_volume, envelope_increasing,
               num_envelope_sweeps, shift_clock_freq_data, counter_width, freq_dividing_ratio,
               initialize, dont_loop,
        input  level, on_flag
    );

    modport slave (
        input  length_tick, env_tick, length_data, initial_volume, envelope_increasing,
               num_envelope_sweeps, shift_clock_freq_data, counter_width, freq_dividing_ratio,
               initialize, dont_loop,
        output level, on_flag
    );
endinterface

// File: rtl/noise_channel.sv
// Game Boy sound channel 4: 15/7-bit LFSR noise with length counter and volume envelope.
// All state is computed as a next-state set so level/on_flag reflect an update one cycle later.
module noise_channel #(
    parameter int BASE_DIV = 12
) (
    input  logic             ac97_bitclk,
    input  logic             reset,
    noise_channel_if.slave   bus
);
    localparam int PRE_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;

    // Shift-register step; in 7-bit mode the feedback is also written into bit 6.
    function automatic logic [14:0] lfsr_step(input logic [14:0] cur, input logic narrow);
        logic       fb;
        logic [14:0] res;
        fb  = cur[0] ^ cur[1];
        res = {fb, cur[14:1]};
        if (narrow) begin
            res[6] = fb;
        end else begin
            res = res;
        end
        return res;
    endfunction

    logic [14:0]      lfsr_r,       lfsr_s;
    logic [3:0]       volume_r,     volume_s;
    logic [6:0]       length_cnt_r, length_cnt_s;
    logic [2:0]       env_cnt_r,    env_cnt_s;
    logic [PRE_W-1:0] prescaler_r,  prescaler_s;
    logic [17:0]      divider_r,    divider_s;
    logic             init_q_r;
    logic             on_r,         on_s;
    logic [3:0]       level_r,      level_s;

    logic             trigger_s;
    logic             dac_en_s;
    logic             base_tick_s;
    logic             shift_en_s;
    logic             div_wrap_s;
    logic [3:0]       period_base_s;
    logic [17:0]      period_s;

    // Next-state evaluation: trigger, then length/envelope ticks, then LFSR clocking.
    always_comb begin
        lfsr_s       = lfsr_r;
        volume_s     = volume_r;
        length_cnt_s = length_cnt_r;
        env_cnt_s    = env_cnt_r;
        prescaler_s  = prescaler_r;
        divider_s    = divider_r;
        on_s         = on_r;
        level_s      = 4'd0;

        trigger_s     = bus.initialize && !init_q_r;
        dac_en_s      = (bus.initial_volume != 4'd0) || bus.envelope_increasing;
        base_tick_s   = (prescaler_r == PRE_W'(BASE_DIV - 1));
        shift_en_s    = (bus.shift_clock_freq_data < 4'd14);
        period_base_s = (bus.freq_dividing_ratio == 3'd0) ? 4'd1 : {bus.freq_dividing_ratio, 1'b0};
        period_s      = {14'd0, period_base_s} << ({1'b0, bus.shift_clock_freq_data} + 5'd1);
        // A divider already at or past a freshly shortened period wraps on the next base tick.
        div_wrap_s    = base_tick_s && shift_en_s && (divider_r >= (period_s - 18'd1));

        if (trigger_s) begin
            lfsr_s       = 15'h7FFF;
            volume_s     = bus.initial_volume;
            env_cnt_s    = 3'd0;
            length_cnt_s = 7'd64 - {1'b0, bus.length_data};
            prescaler_s  = '0;
            divider_s    = 18'd0;
            on_s         = dac_en_s;
        end else begin
            prescaler_s = base_tick_s ? '0 : (prescaler_r + PRE_W'(1));

            if (base_tick_s && shift_en_s) begin
                divider_s = div_wrap_s ? 18'd0 : (divider_r + 18'd1);
            end else if (!shift_en_s) begin
                divider_s = 18'd0;
            end else begin
                divider_s = divider_r;
            end

            if (div_wrap_s) begin
                lfsr_s = lfsr_step(lfsr_r, bus.counter_width);
            end else begin
                lfsr_s = lfsr_r;
            end

            if (bus.length_tick && bus.dont_loop && (length_cnt_r != 7'd0)) begin
                length_cnt_s = length_cnt_r - 7'd1;
                if (length_cnt_r == 7'd1) begin
                    on_s = 1'b0;
                end else begin
                    on_s = on_r;
                end
            end else begin
                length_cnt_s = length_cnt_r;
            end

            if (bus.env_tick && (bus.num_envelope_sweeps != 3'd0)) begin
                if (({1'b0, env_cnt_r} + 4'd1) >= {1'b0, bus.num_envelope_sweeps}) begin
                    env_cnt_s = 3'd0;
                    if (bus.envelope_increasing && (volume_r != 4'd15)) begin
                        volume_s = volume_r + 4'd1;
                    end else if (!bus.envelope_increasing && (volume_r != 4'd0)) begin
                        volume_s = volume_r - 4'd1;
                    end else begin
                        volume_s = volume_r;
                    end
                end else begin
                    env_cnt_s = env_cnt_r + 3'd1;
                end
            end else begin
                env_cnt_s = env_cnt_r;
            end

            if (!dac_en_s) begin
                on_s = 1'b0;
            end else begin
                on_s = on_s;
            end
        end

        if (on_s && !lfsr_s[0]) begin
            level_s = volume_s;
        end else begin
            level_s = 4'd0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge ac97_bitclk) begin
        if (reset) begin
            lfsr_r       <= 15'h7FFF;
            volume_r     <= 4'd0;
            length_cnt_r <= 7'd0;
            env_cnt_r    <= 3'd0;
            prescaler_r  <= '0;
            divider_r    <= 18'd0;
            init_q_r     <= 1'b0;
            on_r         <= 1'b0;
            level_r      <= 4'd0;
        end else begin
            lfsr_r       <= lfsr_s;
            volume_r     <= volume_s;
            length_cnt_r <= length_cnt_s;
            env_cnt_r    <= env_cnt_s;
            prescaler_r  <= prescaler_s;
            divider_r    <= divider_s;
            init_q_r     <= bus.initialize;
            on_r         <= on_s;
            level_r      <= level_s;
        end
    end

    assign bus.level   = level_r;
    assign bus.on_flag = on_r;
endmodule

// File: tb/tb_noise_channel.sv
// Directed bench for noise_channel: LFSR sequence, length expiry, envelope, freeze, reset.
module tb_noise_channel;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fails = 0;
    logic [14:0] m;

    noise_channel_if bus ();

    noise_channel #(.BASE_DIV(12)) dut (
        .ac97_bitclk (clk),
        .reset       (reset),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns #1 after the edge that sees the rising initialize.
    task automatic pulse_trigger();
        bus.initialize = 1'b0;
        step(1);
        bus.initialize = 1'b1;
        step(1);
    endtask

    task automatic len_pulse();
        bus.length_tick = 1'b1;
        step(1);
        bus.length_tick = 1'b0;
    endtask

    task automatic env_pulse();
        bus.env_tick = 1'b1;
        step(1);
        bus.env_tick = 1'b0;
    endtask

    function automatic logic [14:0] model_shift(input logic [14:0] v, input logic w);
        logic [14:0] nv;
        logic fb;
        fb = v[0] ^ v[1];
        nv = (v >> 1) | (15'(fb) << 14);
        if (w) nv = (nv & ~15'h0040) | (15'(fb) << 6);
        return nv;
    endfunction

    initial begin
        bus.length_tick = 1'b0;           bus.env_tick = 1'b0;
        bus.length_data = 6'd0;           bus.initial_volume = 4'hF;
        bus.envelope_increasing = 1'b0;   bus.num_envelope_sweeps = 3'd0;
        bus.shift_clock_freq_data = 4'd0; bus.counter_width = 1'b0;
        bus.freq_dividing_ratio = 3'd0;   bus.initialize = 1'b0;
        bus.dont_loop = 1'b0;

        step(3);
        check_eq("rst_level", 32'(bus.level), 32'h0);
        check_eq("rst_on", 32'(bus.on_flag), 32'h0);
        reset = 1'b0;
        step(2);
        check_eq("idle_on", 32'(bus.on_flag), 32'h0);

        // 15-bit LFSR, one shift every 24 clocks
        pulse_trigger();
        check_eq("trig_on", 32'(bus.on_flag), 32'h1);
        check_eq("trig_level", 32'(bus.level), 32'h0);
        m = 15'h7FFF;
        for (int j = 1; j <= 20; j++) begin
            step(23);
            check_eq("w15_hold", 32'(bus.level), (m[0] ? 32'h0 : 32'hF));
            step(1);
            m = model_shift(m, 1'b0);
            check_eq("w15_shift", 32'(bus.level), (m[0] ? 32'h0 : 32'hF));
        end

        // 7-bit LFSR, r=1 s=0: shift every 48 clocks, period 127
        bus.counter_width = 1'b1;
        bus.freq_dividing_ratio = 3'd1;
        pulse_trigger();
        m = 15'h7FFF;
        for (int j = 1; j <= 140; j++) begin
            step(48);
            m = model_shift(m, 1'b1);
            check_eq("w7_shift", 32'(bus.level), (m[0] ? 32'h0 : 32'hF));
        end
        bus.counter_width = 1'b0;
        bus.freq_dividing_ratio = 3'd0;

        // Length: 64-62 = 2 ticks to expiry
        bus.length_data = 6'd62;
        bus.dont_loop = 1'b1;
        pulse_trigger();
        check_eq("len_on0", 32'(bus.on_flag), 32'h1);
        len_pulse();
        check_eq("len_on1", 32'(bus.on_flag), 32'h1);
        len_pulse();
        check_eq("len_off", 32'(bus.on_flag), 32'h0);
        check_eq("len_off_level", 32'(bus.level), 32'h0);
        bus.dont_loop = 1'b0;
        pulse_trigger();
        for (int j = 0; j < 100; j++) begin
            len_pulse();
            step(1);
        end
        check_eq("len_loop_on", 32'(bus.on_flag), 32'h1);

        // Trigger coincident with length_tick: tick ignored, fresh load of 2
        bus.dont_loop = 1'b1;
        bus.initialize = 1'b0;
        step(1);
        bus.initialize = 1'b1;
        bus.length_tick = 1'b1;
        step(1);
        bus.length_tick = 1'b0;
        check_eq("coin_on0", 32'(bus.on_flag), 32'h1);
        len_pulse();
        check_eq("coin_on1", 32'(bus.on_flag), 32'h1);
        len_pulse();
        check_eq("coin_off", 32'(bus.on_flag), 32'h0);
        bus.dont_loop = 1'b0;

        // Envelope decreasing from 3, n=1 (freeze LFSR at 4000 after 15 shifts)
        bus.initial_volume = 4'd3;
        bus.num_envelope_sweeps = 3'd1;
        pulse_trigger();
        step(360);
        check_eq("envd_start", 32'(bus.level), 32'h3);
        bus.shift_clock_freq_data = 4'd14;
        step(50);
        check_eq("envd_frozen", 32'(bus.level), 32'h3);
        env_pulse(); check_eq("envd_1", 32'(bus.level), 32'h2);
        env_pulse(); check_eq("envd_2", 32'(bus.level), 32'h1);
        env_pulse(); check_eq("envd_3", 32'(bus.level), 32'h0);
        env_pulse(); check_eq("envd_sat", 32'(bus.level), 32'h0);
        check_eq("envd_on", 32'(bus.on_flag), 32'h1);

        // Envelope increasing from E, n=2
        bus.shift_clock_freq_data = 4'd0;
        bus.initial_volume = 4'hE;
        bus.envelope_increasing = 1'b1;
        bus.num_envelope_sweeps = 3'd2;
        pulse_trigger();
        step(360);
        bus.shift_clock_freq_data = 4'd14;
        check_eq("envi_start", 32'(bus.level), 32'hE);
        env_pulse(); check_eq("envi_1", 32'(bus.level), 32'hE);
        env_pulse(); check_eq("envi_2", 32'(bus.level), 32'hF);
        env_pulse(); env_pulse();
        check_eq("envi_sat", 32'(bus.level), 32'hF);

        // s=14: LFSR never shifts, level stays 0 while on
        bus.initial_volume = 4'hF;
        bus.envelope_increasing = 1'b0;
        bus.num_envelope_sweeps = 3'd0;
        pulse_trigger();
        for (int j = 0; j < 40; j++) begin
            step(250);
            check_eq("s14_level", 32'(bus.level), 32'h0);
        end
        check_eq("s14_on", 32'(bus.on_flag), 32'h1);

        // DAC off blocks trigger
        bus.shift_clock_freq_data = 4'd0;
        bus.initial_volume = 4'd0;
        pulse_trigger();
        check_eq("dac_off_on", 32'(bus.on_flag), 32'h0);
        check_eq("dac_off_level", 32'(bus.level), 32'h0);

        // Reset mid-play with initialize held high: exactly one retrigger after release
        bus.initial_volume = 4'hF;
        pulse_trigger();
        step(360);
        check_eq("play_level", 32'(bus.level), 32'hF);
        reset = 1'b1;
        step(1);
        check_eq("midrst_level", 32'(bus.level), 32'h0);
        check_eq("midrst_on", 32'(bus.on_flag), 32'h0);
        reset = 1'b0;
        step(1);
        check_eq("retrig_on", 32'(bus.on_flag), 32'h1);
        check_eq("retrig_level", 32'(bus.level), 32'h0);
        step(360);
        check_eq("retrig_once", 32'(bus.level), 32'hF);

        // DAC switched off while playing drops on_flag
        bus.initial_volume = 4'd0;
        step(1);
        check_eq("dac_drop_on", 32'(bus.on_flag), 32'h0);
        check_eq("dac_drop_level", 32'(bus.level), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
